fc_argmax: RTL and testbench

//   Classifier stage directly downstream of the LeNet full-connection layer.

---
 rtl/lenet_pkg.sv | 27 ++
 rtl/fc_argmax_cmp.sv | 25 ++
 rtl/fc_argmax.sv | 131 +++++++++++++
 tb/tb_fc_argmax.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet definitions.
//   - FSM state encodings for the classifier stage (IDLE/SCAN/DONE)
//   - clog2 helper used to validate index widths at elaboration
//   - score_width(): width of one FC output score (2*BITWIDTH). The same
//     function is used by full_connection, so both sides agree on the slicing.
package lenet_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of one packed score produced by the full-connection layer.
  function automatic int score_width(input int bitwidth);
    return 2 * bitwidth;
  endfunction

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_argmax_cmp.sv
// Combinational signed compare-select for the argmax scan.
//   cand/cand_idx     : candidate score and its class index
//   cur_max/cur_idx   : running maximum and its index
//   nxt_max/nxt_idx   : updated running maximum
// The candidate wins only when strictly greater, so ties keep the earlier
// (lower) index that is already held in cur_idx.
module fc_argmax_cmp #(
  parameter int W  = 64,
  parameter int IW = 4
) (
  input  logic [W-1:0]  cand,
  input  logic [IW-1:0] cand_idx,
  input  logic [W-1:0]  cur_max,
  input  logic [IW-1:0] cur_idx,
  output logic [W-1:0]  nxt_max,
  output logic [IW-1:0] nxt_idx
);

  logic take;

  assign take    = $signed(cand) > $signed(cur_max);
  assign nxt_max = take ? cand     : cur_max;
  assign nxt_idx = take ? cand_idx : cur_idx;

endmodule

// File: rtl/fc_argmax.sv
// Final classifier stage after the LeNet full-connection layer.
// Captures a vector of OUTLEN signed scores, scans it one entry per clock and
// returns the index and value of the largest score.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_ready is high only in IDLE
//   in_result            OUTLEN packed scores, score k at [k*SW +: SW]
//   out_valid/out_ready  output handshake; out_valid is high only in DONE
//   out_class/out_score  registered argmax index / maximum value
module fc_argmax
  import lenet_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int OUTLEN   = 10,
  parameter int IDXW     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [score_width(BITWIDTH)*OUTLEN-1:0] in_result,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [IDXW-1:0]                      out_class,
  output logic [score_width(BITWIDTH)-1:0]     out_score
);

  localparam int SW = score_width(BITWIDTH);

  generate
    if (OUTLEN < 1 || OUTLEN > 256 || clog2(OUTLEN) > IDXW) begin : g_bad_params
      $error("fc_argmax: OUTLEN must be 1..256 and fit in IDXW bits");
    end
  endgenerate

  logic [1:0]           state_reg;
  logic [SW*OUTLEN-1:0] cap_reg;
  logic [SW-1:0]        max_reg;
  logic [IDXW-1:0]      idx_reg;
  logic [IDXW-1:0]      cnt_reg;
  logic [IDXW-1:0]      out_class_reg;
  logic [SW-1:0]        out_score_reg;

  // Unpacked view of the captured vector so the scan can index by counter.
  logic [SW-1:0] score [OUTLEN];

  genvar gi;
  generate
    for (gi = 0; gi < OUTLEN; gi++) begin : g_unpack
      assign score[gi] = cap_reg[gi*SW +: SW];
    end
  endgenerate

  logic [SW-1:0]   nxt_max;
  logic [IDXW-1:0] nxt_idx;
  logic            cnt_last;

  fc_argmax_cmp #(
    .W  (SW),
    .IW (IDXW)
  ) u_cmp (
    .cand     (score[cnt_reg]),
    .cand_idx (cnt_reg),
    .cur_max  (max_reg),
    .cur_idx  (idx_reg),
    .nxt_max  (nxt_max),
    .nxt_idx  (nxt_idx)
  );

  assign cnt_last  = (cnt_reg == IDXW'(OUTLEN - 1));
  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign out_class = out_class_reg;
  assign out_score = out_score_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cap_reg       <= '0;
      max_reg       <= '0;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      out_class_reg <= '0;
      out_score_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            // Score 0 seeds the running max straight from the input bus,
            // so the scan starts at entry 1 on the next cycle.
            cap_reg <= in_result;
            max_reg <= in_result[SW-1:0];
            idx_reg <= '0;
            if (OUTLEN == 1) begin
              cnt_reg       <= '0;
              out_class_reg <= '0;
              out_score_reg <= in_result[SW-1:0];
              state_reg     <= ST_DONE;
            end else begin
              cnt_reg   <= IDXW'(1);
              state_reg <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          max_reg <= nxt_max;
          idx_reg <= nxt_idx;
          if (cnt_last) begin
            // Last entry: publish the final compare result directly and
            // hold the counter so it never passes OUTLEN-1.
            out_class_reg <= nxt_idx;
            out_score_reg <= nxt_max;
            state_reg     <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Directed testbench for fc_argmax (BITWIDTH=32, OUTLEN=10, IDXW=4).
// Latency is counted with the accepting edge as edge 1, so the default
// configuration shows out_valid after the 10th edge (OUTLEN+1 cycle period).
module tb_fc_argmax;

  localparam int BW = 32;
  localparam int N  = 10;
  localparam int IW = 4;
  localparam int SW = 2 * BW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SW*N-1:0]   in_result = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [IW-1:0]     out_class;
  logic [SW-1:0]     out_score;

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] sc [N];

  fc_argmax #(
    .BITWIDTH (BW),
    .OUTLEN   (N),
    .IDXW     (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pack();
    for (int k = 0; k < N; k++) in_result[k*SW +: SW] = sc[k];
  endtask

  task automatic set_vec(input int id);
    int v [N];
    case (id)
      1: v = '{0, 1, 2, 3, 4, 5, 6, 7, 80, 9};
      2: v = '{-5, -3, -3, -9, -10, -20, -30, -40, -50, -100};
      3: v = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
      5: v = '{50, 50, 50, 50, 50, 50, 50, 50, 50, 51};
      6: v = '{3, -7, 12, 12, 0, -1, 5, 11, 2, 9};
      7: v = '{1, 1, 1, 1, 1, 1, -2, 99, 98, 0};
      default: v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    endcase
    for (int k = 0; k < N; k++) sc[k] = SW'(v[k]);
    if (id == 4) begin
      for (int k = 0; k < N; k++) sc[k] = 64'h8000_0000_0000_0000;
      sc[3] = 64'h8000_0000_0000_0001;
    end
    if (id == 0) begin
      for (int k = 0; k < N; k++) sc[k] = 64'h7FFF_FFFF_FFFF_FFFF;
    end
  endtask

  // Present in_result with in_valid until the accepting edge; returns at #1 after it.
  task automatic accept(output bit ok);
    int t;
    t = 0;
    in_valid = 1'b1;
    while (!in_ready && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called at #1 after the accepting edge; lat counts that edge as 1.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_case(input int id, input logic [IW-1:0] exp_cls,
                          input logic [SW-1:0] exp_score, input string name);
    bit ok;
    int lat;
    set_vec(id);
    pack();
    accept(ok);
    wait_result(lat);
    checks++;
    if (!ok || lat !== 10) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges (accepted=%0d) want 10", name, lat, ok);
    end
    checks++;
    if (out_class !== exp_cls) begin
      errors++;
      $display("FAIL %s_class: got %0d want %0d", name, out_class, exp_cls);
    end
    checks++;
    if (out_score !== exp_score) begin
      errors++;
      $display("FAIL %s_score: got %h want %h", name, out_score, exp_score);
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
    $display("case %s: class=%0d score=%h latency=%0d", name, out_class, out_score, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_class !== '0) begin errors++; $display("FAIL reset_out_class: got %0d want 0", out_class); end
    checks++;
    if (out_score !== '0) begin errors++; $display("FAIL reset_out_score: got %h want 0", out_score); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_basic();
    run_case(1, 4'd8, 64'd80, "basic");
  endtask

  task automatic test_ties();
    run_case(2, 4'd1, -64'sd3, "negative_tie");
    run_case(3, 4'd0, 64'd7, "all_equal");
  endtask

  task automatic test_signed();
    run_case(4, 4'd3, 64'h8000_0000_0000_0001, "most_negative");
    run_case(5, 4'd9, 64'd51, "last_slot");
  endtask

  task automatic test_backpressure();
    bit ok;
    bit stable;
    int lat;
    set_vec(1);
    pack();
    accept(ok);
    // Upstream changes while the block is busy must not leak into the scan.
    set_vec(0);
    pack();
    in_valid = 1'b1;
    wait_result(lat);
    checks++;
    if (!ok || out_class !== 4'd8 || out_score !== 64'd80) begin
      errors++;
      $display("FAIL bp_isolation: got class=%0d score=%h want 8/80", out_class, out_score);
    end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== 4'd8 || out_score !== 64'd80)
        stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_stable: outputs moved under backpressure (valid=%b ready=%b class=%0d) want 1/0/8",
               out_valid, in_ready, out_class);
    end
    in_valid = 1'b0;
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    $display("backpressure: class=%0d stable=%0d", out_class, stable);
  endtask

  task automatic test_reset_abort();
    bit ok;
    set_vec(5);
    pack();
    accept(ok);
    // cnt is 1 after the accepting edge; four more edges bring it to 5.
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_handshake: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_class !== '0 || out_score !== '0) begin
      errors++;
      $display("FAIL abort_outputs: class=%0d score=%h want 0/0", out_class, out_score);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset_abort: in_ready=%b out_valid=%b", in_ready, out_valid);
    run_case(6, 4'd2, 64'd12, "after_abort");
  endtask

  task automatic test_back_to_back();
    int cyc;
    int rise [$];
    logic [IW-1:0] res [$];
    logic prev_ready;
    bit switched;
    out_ready = 1'b1;
    set_vec(1);
    pack();
    in_valid = 1'b1;
    prev_ready = in_ready;
    switched = 1'b0;
    cyc = 0;
    while (cyc < 60 && (rise.size() < 2 || res.size() < 2)) begin
      @(posedge clk); #1;
      cyc++;
      if (!in_ready && !switched) begin
        switched = 1'b1;
        set_vec(7);
        pack();
      end
      if (in_ready && !prev_ready) rise.push_back(cyc);
      if (out_valid) res.push_back(out_class);
      prev_ready = in_ready;
    end
    in_valid = 1'b0;
    checks++;
    if (rise.size() < 2 || (rise[1] - rise[0]) !== 11) begin
      errors++;
      $display("FAIL b2b_period: got %0d cycles want 11",
               (rise.size() < 2) ? -1 : (rise[1] - rise[0]));
    end
    checks++;
    if (res.size() < 2 || res[0] !== 4'd8 || res[1] !== 4'd7) begin
      errors++;
      $display("FAIL b2b_classes: got %0d results first=%0d second=%0d want 8,7", res.size(),
               (res.size() > 0) ? res[0] : 4'd0, (res.size() > 1) ? res[1] : 4'd0);
    end
    // Drain any vector accepted in the meantime.
    cyc = 0;
    while (!in_ready && cyc < 40) begin @(posedge clk); #1; cyc++; end
    out_ready = 1'b0;
    $display("back_to_back: results=%0d rises=%0d", res.size(), rise.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_signed();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
